// File: rtl/button_mode_ctrl.sv
// Push-button front end: 2-flop sync, debounce, and short/long press classification.
// Long-press support (LONG_HELD state, hold counter, led_en toggling) requires BTN_MODE_LONG_PRESS_EN.
module button_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic short_pulse,
    output logic long_pulse,
    output logic pattern_select,
    output logic led_en
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_MODE_LONG_PRESS_EN
    localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPressed  = 2'd1,
        StLongHeld = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1
    } state_e;
`endif

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 2) begin : gen_bad_params
        $error("button_mode_ctrl: DEBOUNCE_CYCLES must be >= 1 and LONG_PRESS_CYCLES > 1");
    end

    // Synchroniser, reset to the released level.
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer, kept in pressed = 1 polarity.
    logic           raw_level;
    logic           stable_q, stable_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;

    assign raw_level = ~sync2_q;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (raw_level != stable_q) begin
            if (db_cnt_q == DbLast) begin
                stable_d = raw_level;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Press classification FSM.
    state_e state_q, state_d;
    logic   level_prev_q;
    logic   level_rise;
    logic   short_q, short_d;
    logic   pat_q, pat_d;

    assign level_rise = stable_q & ~level_prev_q;

`ifdef BTN_MODE_LONG_PRESS_EN
    logic             long_q, long_d;
    logic             led_q, led_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [HoldW-1:0] hold_inc;

    // Saturating so a button held forever never wraps back into a second long event.
    assign hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + HoldW'(1);
`endif

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        pat_d   = pat_q;
`ifdef BTN_MODE_LONG_PRESS_EN
        long_d  = 1'b0;
        led_d   = led_q;
        hold_d  = hold_q;
`endif
        case (state_q)
            StIdle: begin
                if (level_rise) begin
                    state_d = StPressed;
`ifdef BTN_MODE_LONG_PRESS_EN
                    hold_d  = '0;
`endif
                end
            end
            StPressed: begin
                // Release is tested first so it wins over a coincident long threshold.
                if (!stable_q) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                    pat_d   = ~pat_q;
                end
`ifdef BTN_MODE_LONG_PRESS_EN
                else begin
                    hold_d = hold_inc;
                    if (hold_inc == HoldLast) begin
                        state_d = StLongHeld;
                        long_d  = 1'b1;
                        led_d   = ~led_q;
                    end
                end
`endif
            end
`ifdef BTN_MODE_LONG_PRESS_EN
            StLongHeld: begin
                hold_d = hold_inc;
                if (!stable_q) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            level_prev_q <= 1'b0;
            short_q      <= 1'b0;
            pat_q        <= 1'b0;
`ifdef BTN_MODE_LONG_PRESS_EN
            long_q       <= 1'b0;
            led_q        <= 1'b1;
            hold_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            level_prev_q <= stable_q;
            short_q      <= short_d;
            pat_q        <= pat_d;
`ifdef BTN_MODE_LONG_PRESS_EN
            long_q       <= long_d;
            led_q        <= led_d;
            hold_q       <= hold_d;
`endif
        end
    end

    assign btn_level      = stable_q;
    assign short_pulse    = short_q;
    assign pattern_select = pat_q;
`ifdef BTN_MODE_LONG_PRESS_EN
    assign long_pulse     = long_q;
    assign led_en         = led_q;
`else
    assign long_pulse     = 1'b0;
    assign led_en         = 1'b1;
`endif

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Bench for button_mode_ctrl: event-level reference model checked every cycle, plus
// directed scenarios with hand-computed latencies and event counts.
module tb_button_mode_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned L = 16;
`ifdef BTN_MODE_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic btn_level, short_pulse, long_pulse, pattern_select, led_en;

    button_mode_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .pattern_select(pattern_select),
        .led_en        (led_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the level flips once D consecutive synchronised samples disagree
    // with it; a press ends short unless it stayed held L edges past its rise.
    bit hist [D+2];
    bit m_level, m_short, m_long, m_pat, m_led, m_active, m_long_done;
    int m_edge, m_start;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D + 2; k++) hist[k] = 1'b1;
            m_level = 0; m_short = 0; m_long = 0; m_pat = 0; m_led = 1;
            m_active = 0; m_long_done = 0; m_edge = 0; m_start = 0;
        end else begin
            bit flip;
            m_edge++;
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn_n;
            m_short = 0;
            m_long  = 0;
            if (m_active && !m_level) begin
                if (!m_long_done) begin
                    m_short = 1;
                    m_pat   = !m_pat;
                end
                m_active = 0;
            end else if (!m_active && m_level) begin
                m_active    = 1;
                m_long_done = 0;
                m_start     = m_edge - 1;
            end else if (m_active && m_level && LongEn && !m_long_done &&
                         (m_edge - m_start == int'(L))) begin
                m_long      = 1;
                m_led       = !m_led;
                m_long_done = 1;
            end
            flip = 1;
            for (int k = 2; k <= D + 1; k++) if ((!hist[k]) == m_level) flip = 0;
            if (flip) m_level = !m_level;
        end
    end

    // Per-cycle compare plus event bookkeeping observed from the DUT.
    int cyc = 0;
    int rise_cnt = 0, short_cnt = 0, long_cnt = 0;
    int last_rise = -1, last_fall = -1, last_short = -1, last_long = -1;
    logic lvl_seen = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        chk("btn_level", btn_level, m_level);
        chk("short_pulse", short_pulse, m_short);
        chk("long_pulse", long_pulse, m_long);
        chk("pattern_select", pattern_select, m_pat);
        chk("led_en", led_en, m_led);
        if (btn_level === 1'b1 && lvl_seen !== 1'b1) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (btn_level === 1'b0 && lvl_seen === 1'b1) last_fall = cyc;
        if (short_pulse === 1'b1) begin
            short_cnt++;
            last_short = cyc;
        end
        if (long_pulse === 1'b1) begin
            long_cnt++;
            last_long = cyc;
        end
        lvl_seen = btn_level;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"}, btn_level, 1'b0);
        chk({tag, "_short"}, short_pulse, 1'b0);
        chk({tag, "_long"}, long_pulse, 1'b0);
        chk({tag, "_pat"}, pattern_select, 1'b0);
        chk({tag, "_led"}, led_en, 1'b1);
    endtask

    int t0, r0, s0, l0;

    initial begin
        // Reset with the button already held.
        rst_n = 1'b0;
        btn_n = 1'b0;
        wait_cycles(3);
        chk_reset_outputs("reset");
        r0 = rise_cnt;
        t0 = cyc;
        rst_n = 1'b1;
        wait_cycles(10);
        chk_int("reset_press_count", rise_cnt - r0, 1);
        chk_int("reset_press_latency", last_rise - t0, 6);
        chk_int("reset_no_pulses", short_cnt + long_cnt, 0);
        btn_n = 1'b1;
        wait_cycles(30);
        chk_int("reset_press_short", short_cnt, 1);
        chk("reset_press_pat", pattern_select, 1'b1);

        // Glitch shorter than the debounce window.
        r0 = rise_cnt; s0 = short_cnt; l0 = long_cnt;
        btn_n = 1'b0;
        wait_cycles(3);
        btn_n = 1'b1;
        wait_cycles(20);
        chk_int("glitch_rises", rise_cnt - r0, 0);
        chk_int("glitch_pulses", (short_cnt - s0) + (long_cnt - l0), 0);

        // Short press from a fresh reset.
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        chk("short_pre_pat", pattern_select, 1'b0);
        t0 = cyc; r0 = rise_cnt; s0 = short_cnt; l0 = long_cnt;
        btn_n = 1'b0;
        wait_cycles(10);
        btn_n = 1'b1;
        wait_cycles(20);
        chk_int("short_rise_latency", last_rise - t0, 6);
        chk_int("short_fall_time", last_fall - t0, 16);
        chk_int("short_pulse_time", last_short - t0, 17);
        chk_int("short_count", short_cnt - s0, 1);
        chk_int("short_no_long", long_cnt - l0, 0);
        chk("short_pat", pattern_select, 1'b1);
        chk("short_led", led_en, 1'b1);

        // 40-cycle hold.
        t0 = cyc; s0 = short_cnt; l0 = long_cnt;
        btn_n = 1'b0;
        wait_cycles(40);
        btn_n = 1'b1;
        wait_cycles(20);
        if (LongEn) begin
            chk_int("long_count", long_cnt - l0, 1);
            chk_int("long_pulse_time", last_long - t0, 22);
            chk_int("long_no_short", short_cnt - s0, 0);
            chk("long_led", led_en, 1'b0);
            chk("long_pat", pattern_select, 1'b1);
        end else begin
            chk_int("hold_short_count", short_cnt - s0, 1);
            chk_int("hold_short_time", last_short - t0, 47);
            chk_int("hold_no_long", long_cnt - l0, 0);
            chk("hold_led", led_en, 1'b1);
            chk("hold_pat", pattern_select, 1'b0);
        end

        // Bounce, then a clean hold.
        r0 = rise_cnt; s0 = short_cnt;
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            wait_cycles(2);
            btn_n = 1'b1;
            wait_cycles(2);
        end
        chk_int("bounce_no_rise", rise_cnt - r0, 0);
        t0 = cyc;
        btn_n = 1'b0;
        wait_cycles(10);
        btn_n = 1'b1;
        wait_cycles(20);
        chk_int("bounce_rises", rise_cnt - r0, 1);
        chk_int("bounce_latency", last_rise - t0, 6);
        chk_int("bounce_shorts", short_cnt - s0, 1);

        // Reset while a press is in progress.
        btn_n = 1'b0;
        wait_cycles(8);
        chk("midreset_pre_level", btn_level, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        wait_cycles(1);
        t0 = cyc; r0 = rise_cnt; s0 = short_cnt; l0 = long_cnt;
        rst_n = 1'b1;
        wait_cycles(40);
        btn_n = 1'b1;
        wait_cycles(30);
        chk_int("midreset_rise_latency", last_rise - t0, 6);
        if (LongEn) begin
            chk_int("midreset_long", long_cnt - l0, 1);
            chk_int("midreset_short", short_cnt - s0, 0);
            chk("midreset_led", led_en, 1'b0);
        end else begin
            chk_int("midreset_short", short_cnt - s0, 1);
            chk_int("midreset_long", long_cnt - l0, 0);
            chk("midreset_led", led_en, 1'b1);
            chk("midreset_pat", pattern_select, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_mode_ctrl.md
# button_mode_ctrl

User-input front end for the fabric LED pattern logic on the BeagleV-Fire (MPFS025T). It synchronises and debounces a raw active-low push button, then classifies each press as short or long. A short press toggles `pattern_select`, which drives the pattern FSM: 0 = chase, 1 = blink_all. A long press toggles `led_en`, the LED output gate.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new button level (20 ms at 50 MHz); must be ≥ 1.
- `LONG_PRESS_CYCLES`, 50_000_000: debounced hold duration that classifies a press as long (1 s at 50 MHz); must be > 1.

Ports:
- `clk`, input, 1: fabric clock, 50 MHz.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_n`, input, 1: raw button; asynchronous to `clk`; 0 = pressed.
- `btn_level`, output, 1: debounced button state; 1 = pressed.
- `short_pulse`, output, 1: one-cycle strobe when a short press is released.
- `long_pulse`, output, 1: one-cycle strobe when the hold reaches the long threshold.
- `pattern_select`, output, 1: toggles on each short press; feeds the pattern FSM.
- `led_en`, output, 1: toggles on each long press; gates the LEDs downstream.

## Operation

- **Synchroniser:** two flops on `btn_n`. Both reset to 1 (released).
- **Debouncer:**
  - Holds a stable level and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While the synchronised level equals the stable level, the counter is held at 0.
  - While they differ, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the stable level takes the new value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never changes `btn_level`.
- **Hold counter:** width `$clog2(LONG_PRESS_CYCLES+1)`. It saturates at `LONG_PRESS_CYCLES` and never wraps.
- **FSM** (states IDLE, PRESSED, LONG_HELD):
  - IDLE: on a `btn_level` rising edge → PRESSED, with the hold counter cleared.
  - PRESSED, hold counter increments each cycle:
    - If `btn_level` falls → IDLE, with `short_pulse` = 1 for one cycle and `pattern_select` inverted.
    - Else, if the hold count reaches `LONG_PRESS_CYCLES-1` → LONG_HELD, with `long_pulse` = 1 for one cycle and `led_en` inverted.
    - If release and the threshold occur in the same cycle, release wins (short press).
  - LONG_HELD: no pulses. On a `btn_level` fall → IDLE. A long press never also produces a short event.
  - Illegal encoding → IDLE, with no output changes.
- **Reset values:** `btn_level` = 0, `short_pulse` = 0, `long_pulse` = 0, `pattern_select` = 0, `led_en` = 1, FSM = IDLE, all counters = 0.
- **Reset mid-press:**
  - All outputs return to their reset values immediately (asynchronous).
  - After release of reset, a button still held is debounced afresh and is treated as a new press.

## Timing

- All outputs are registered. There are no combinational paths from `btn_n`.
- **Press latency:** `btn_level` rises exactly `DEBOUNCE_CYCLES+2` edges after the first edge that samples a clean low on `btn_n`. Release latency is identical.
- **Short press:** `short_pulse` and the `pattern_select` toggle occur on the edge after `btn_level` falls. The pulse is high for exactly 1 cycle.
- **Long press:** `long_pulse` and the `led_en` toggle occur `LONG_PRESS_CYCLES` edges after `btn_level` rises. The pulse is high for exactly 1 cycle.
- **Press spacing:** the minimum gap between two detected presses is `2*DEBOUNCE_CYCLES`.

## Configuration

Macro `BTN_MODE_LONG_PRESS_EN`:
- **Defined:** long-press detection exactly as specified above.
- **Undefined:**
  - The LONG_HELD state and the hold counter are removed.
  - Every press/release pair is a short press, regardless of duration.
  - `long_pulse` is tied to 0 and `led_en` is tied to 1.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES` = 4, `LONG_PRESS_CYCLES` = 16.

- **Reset:** assert `rst_n` = 0 with `btn_n` = 0 → all outputs at reset values. Release reset → `btn_level` = 1 after 6 edges; no pulses.
- **Glitch:** pulse `btn_n` low for 3 cycles → `btn_level` stays 0; `short_pulse` and `long_pulse` never assert.
- **Short press:** hold `btn_n` low for 10 cycles, then release → `btn_level` rises 6 edges after the press. One `short_pulse`, 1 cycle wide, follows `btn_level`'s fall. `pattern_select` goes 0→1; `led_en` stays 1.
- **Long press:** hold `btn_n` low for 40 cycles → `long_pulse` 16 edges after `btn_level` rises, and `led_en` goes 1→0. Release → no `short_pulse`; `pattern_select` unchanged.
- **Bounce then press:** alternate `btn_n` every 2 cycles for 20 cycles, then hold low for 10 → exactly one press detected, with `btn_level` rising 6 edges after the stable low begins.
- **Mid-press reset, macro undefined:** assert `rst_n` during PRESSED → outputs reset immediately. With `BTN_MODE_LONG_PRESS_EN` undefined, a 40-cycle hold yields one `short_pulse`, `long_pulse` stays 0 and `led_en` stays 1.
